// File: rtl/mem_port_req_if.sv
// rtl/mem_port_req_if.sv - signal bundle between client, mem_port_req and the memory block
//
// Purpose: groups the client request, memory-block and read-response signals of
// mem_port_req so they travel as one port. The slave modport is the view of
// mem_port_req itself; the master modport is the view of the surrounding client
// and memory block together.
//
// Signals (direction as seen by the slave):
//   request  : req_valid, req_wr, req_excl, req_addr[38:0], req_phy[31:0],
//              req_wdata[532:0] in; req_ready out
//   memory   : stall, rden_out, rddata[532:0], rdphydata[39:0] in;
//              rdaddr0, wraddr0 [38:0], rdphydata0[39:0], rden_in, wren_in,
//              wrdata[532:0] out
//   response : resp_ready in; resp_valid, resp_data[532:0], resp_phy[31:0] out
//   control  : flush in; err out
interface mem_port_req_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic         req_excl;
  logic [38:0]  req_addr;
  logic [31:0]  req_phy;
  logic [532:0] req_wdata;
  logic         stall;
  logic [38:0]  rdaddr0;
  logic [38:0]  wraddr0;
  logic [39:0]  rdphydata0;
  logic         rden_in;
  logic         wren_in;
  logic [532:0] wrdata;
  logic         rden_out;
  logic [532:0] rddata;
  logic [39:0]  rdphydata;
  logic         resp_valid;
  logic         resp_ready;
  logic [532:0] resp_data;
  logic [31:0]  resp_phy;
  logic         flush;
  logic         err;

  modport slave (
    input  req_valid, req_wr, req_excl, req_addr, req_phy, req_wdata,
    input  stall, rden_out, rddata, rdphydata, resp_ready, flush,
    output req_ready, rdaddr0, wraddr0, rdphydata0, rden_in, wren_in, wrdata,
    output resp_valid, resp_data, resp_phy, err
  );

  modport master (
    output req_valid, req_wr, req_excl, req_addr, req_phy, req_wdata,
    output stall, rden_out, rddata, rdphydata, resp_ready, flush,
    input  req_ready, rdaddr0, wraddr0, rdphydata0, rden_in, wren_in, wrdata,
    input  resp_valid, resp_data, resp_phy, err
  );
endinterface

// File: rtl/mem_port_req.sv
// rtl/mem_port_req.sv - client port to a memory block with outstanding-read tracking and in-order response buffer
//
// Purpose: accepts client read/write requests into a single request register
// that drives the memory block, counts reads in flight (up to OUTST), buffers
// read returns in an OUTST-deep FIFO and hands them back in issue order. A flush
// pulse stops acceptance until every read has been popped. err is sticky.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_req_if.slave (request, memory-block, response, flush, err)
//
// Parameter:
//   OUTST : max outstanding reads and response FIFO depth; power of two, 2..64
//
// Optional feature macro: MEMPORT_RDCHK_EN
//   When defined, every read return's sequence tag rdphydata[39:32] is compared
//   with an expected-sequence counter; a mismatch sets err (data still buffered).
module mem_port_req #(
  parameter int OUTST = 16
) (
  input  logic      clk,
  input  logic      rst,
  mem_port_req_if.slave bus
);

  localparam int CW = $clog2(OUTST + 1);
  localparam int AW = $clog2(OUTST);
  localparam logic [CW-1:0] OUTST_C = CW'(OUTST);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state;
  logic [CW-1:0]  outst_cnt;
  logic [CW-1:0]  fifo_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [7:0]     seq;
  logic [532:0]   fifo_data [OUTST];
  logic [31:0]    fifo_phy  [OUTST];

  logic busy;
  logic accept;
  logic rd_accept;
  logic pop;
  logic push;
  logic fifo_full;
  logic zero_inflight;
  logic seq_err;

  assign busy = bus.rden_in | bus.wren_in;

  // Writes bypass the outstanding limit; only reads need response space.
  assign bus.req_ready = (state == RUN) && (!busy || !bus.stall) &&
                         (bus.req_wr || (outst_cnt < OUTST_C));

  assign accept    = bus.req_valid && bus.req_ready;
  assign rd_accept = accept && !bus.req_wr;

  assign bus.resp_valid = (fifo_cnt != '0);
  assign pop            = bus.resp_valid && bus.resp_ready;
  assign fifo_full      = (fifo_cnt == OUTST_C);

  // Every counted read that is not already buffered is still in flight; when
  // the two counts match, a return has nothing to belong to.
  assign zero_inflight = (outst_cnt == fifo_cnt);
  assign push          = bus.rden_out && !zero_inflight && !fifo_full;

  assign bus.resp_data = bus.resp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.resp_phy  = bus.resp_valid ? fifo_phy[rd_ptr]  : '0;

`ifdef MEMPORT_RDCHK_EN
  logic [7:0] exp_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_seq <= 8'd0;
    end else if (bus.rden_out) begin
      exp_seq <= exp_seq + 8'd1;
    end
  end

  assign seq_err = bus.rden_out && (bus.rdphydata[39:32] != exp_seq);
`else
  logic unused_rdseq;
  assign unused_rdseq = ^bus.rdphydata[39:32];
  assign seq_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      bus.rden_in    <= 1'b0;
      bus.wren_in    <= 1'b0;
      bus.rdaddr0    <= '0;
      bus.wraddr0    <= '0;
      bus.wrdata     <= '0;
      bus.rdphydata0 <= '0;
      bus.err        <= 1'b0;
      outst_cnt      <= '0;
      fifo_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      seq            <= 8'd0;
    end else begin
      case (state)
        RUN:     if (bus.flush) state <= FLUSH;
        FLUSH:   if ((outst_cnt == '0) && !busy) state <= RUN;
        default: state <= RUN;
      endcase

      // accept already implies the register is free or being consumed, so a
      // load never overwrites a request the memory block has not taken.
      if (accept) begin
        if (bus.req_wr) begin
          bus.wraddr0 <= bus.req_addr;
          bus.wrdata  <= bus.req_wdata;
          bus.wren_in <= 1'b1;
          bus.rden_in <= 1'b0;
        end else begin
          bus.rdaddr0    <= {bus.req_addr[38], bus.req_excl, bus.req_addr[36:0]};
          bus.rdphydata0 <= {seq, bus.req_phy};
          bus.rden_in    <= 1'b1;
          bus.wren_in    <= 1'b0;
        end
      end else if (!bus.stall) begin
        bus.rden_in <= 1'b0;
        bus.wren_in <= 1'b0;
      end

      if (rd_accept) seq <= seq + 8'd1;

      if (rd_accept && !pop) begin
        outst_cnt <= outst_cnt + CW'(1);
      end else if (!rd_accept && pop) begin
        outst_cnt <= outst_cnt - CW'(1);
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end

      if ((bus.rden_out && (zero_inflight || fifo_full)) || seq_err) begin
        bus.err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.rddata;
      fifo_phy[wr_ptr]  <= bus.rdphydata[31:0];
    end
  end

endmodule

// File: doc/mem_port_req.md
MEM_PORT_REQ -- requirements
Module: mem_port_req

Interface
REQ-001 Parameter OUTST, default 16, max outstanding reads per port; power of two, 2..64.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  client request present.
REQ-005 req_ready  output  1  request accepted this edge when high with req_valid.
REQ-006 req_wr  input  1  1=write, 0=read.
REQ-007 req_excl  input  1  read-for-ownership; drives bit 37 of rdaddr0.
REQ-008 req_addr  input  39  request address.
REQ-009 req_phy  input  32  client sideband, returned with read data.
REQ-010 req_wdata  input  533  write data (8*66+5).
REQ-011 stall  input  1  memory block stall; no request consumed on an edge where high.
REQ-012 rdaddr0, wraddr0  output  39 each  read / write address to memory block.
REQ-013 rdphydata0  output  40  {seq[7:0], req_phy[31:0]} of the read.
REQ-014 rden_in, wren_in  output  1 each  read / write enable to memory block.
REQ-015 wrdata  output  533  write data to memory block.
REQ-016 rden_out  input  1  read return strobe from memory block.
REQ-017 rddata  input  533  read return data.
REQ-018 rdphydata  input  40  returned sideband.
REQ-019 resp_valid  output  1; resp_ready  input  1  read response handshake.
REQ-020 resp_data  output  533; resp_phy  output  32  response payload.
REQ-021 flush  input  1  pulse: stop accepting until all reads are popped.
REQ-022 err  output  1  sticky protocol error.

Function
REQ-023 Single request register holds outputs; contents held unchanged on every edge with stall=1.
REQ-024 Request register consumed on edge with stall=0; on that edge load next accepted request, else clear rden_in/wren_in.
REQ-025 req_ready = (state==RUN) && (!(rden_in||wren_in) || !stall) && (req_wr || outst_cnt<OUTST).
REQ-026 Read: rdaddr0=req_addr with bit37=req_excl, rden_in=1, wren_in=0; write: wraddr0=req_addr, wrdata=req_wdata, wren_in=1, rden_in=0.
REQ-027 Latency: accepted at edge N -> outputs valid after edge N; memory block consumes at first stall=0 edge.
REQ-028 outst_cnt (0..OUTST) +1 on read accept, -1 on response pop; both same edge -> unchanged; writes never counted.
REQ-029 seq (8 bit) increments per read accept, wraps 255->0.
REQ-030 Response FIFO depth OUTST; push on every rden_out edge (rddata, rdphydata[31:0]); never back-pressures memory block.
REQ-031 resp_valid = FIFO not empty; pop on resp_valid&&resp_ready; push and pop same edge -> occupancy unchanged; push at full drops data and sets err.
REQ-032 Responses delivered in issue order; resp_valid rises the cycle after the rden_out edge.
REQ-033 States RUN, FLUSH: RUN->FLUSH on flush=1; FLUSH->RUN when outst_cnt==0 and request register empty; flush in FLUSH ignored.
REQ-034 rden_out with zero reads in flight sets err; response is dropped.

Reset
REQ-035 rst clears: state=RUN, rden_in=wren_in=0, outst_cnt=0, seq=0, FIFO empty, resp_valid=0, err=0; address/data outputs 0.
REQ-036 Reset mid-operation discards in-flight requests and buffered responses; no replay.

Configuration
REQ-037 MEMPORT_RDCHK_EN defined: expected-seq counter compares rdphydata[39:32] per rden_out; mismatch sets err, data still pushed.
REQ-038 MEMPORT_RDCHK_EN undefined: no seq comparison; err only from REQ-031/REQ-034.

Verification
REQ-039 Read addr 0x12_3456_7890, stall=0 -> rden_in=1 one cycle, rdphydata0[39:32]=0; rden_out 48 cycles later -> resp_valid next cycle, resp_data=rddata.
REQ-040 Read issued with stall high 5 cycles -> rdaddr0/rden_in stable 5 cycles, req_ready=0, consumed on 6th edge.
REQ-041 16 reads, resp_ready=0 -> req_ready=0 on 17th read, write still accepted; one pop -> read accepted next edge.
REQ-042 flush with 3 reads outstanding -> req_ready=0 until third pop, RUN next cycle.
REQ-043 MEMPORT_RDCHK_EN: return seq 2 when 1 expected -> err=1, held until rst.
REQ-044 rst asserted with 4 outstanding -> all outputs 0 asynchronously, stray rden_out afterward -> err=1, resp_valid=0.
